// File: rtl/regular_topo_link_pipe_pkg.sv
// Shared types for the router-to-router link pipe: channel struct, error flags, per-topology defaults.
// Types and helpers only; no logic, no latency.
package regular_topo_link_pipe_pkg;

    localparam int V_P    = 2;
    localparam int DATAw  = 8;
    localparam int CONGw  = 2;
    localparam int SMARTw = 2;
    localparam int CTRLw  = 2;

    typedef enum logic [1:0] {
        TOPO_LINE  = 2'd0,
        TOPO_RING  = 2'd1,
        TOPO_MESH  = 2'd2,
        TOPO_TORUS = 2'd3
    } topo_e;

    // Torus wrap-around links span the whole die, so they get an extra slice.
    localparam int LINK_STAGES_LINE  = 1;
    localparam int LINK_STAGES_RING  = 1;
    localparam int LINK_STAGES_MESH  = 1;
    localparam int LINK_STAGES_TORUS = 2;

    typedef struct packed {
        logic             hdr;
        logic             tail;
        logic [V_P-1:0]   vc;
        logic [DATAw-1:0] payload;
    } flit_t;

    typedef struct packed {
        flit_t             flit;
        logic              flit_wr;
        logic [V_P-1:0]    credit;
        logic [CONGw-1:0]  congestion;
        logic [SMARTw-1:0] smart_req;
        logic [CTRLw-1:0]  ctrl;
    } smartflit_chanel_t;

    typedef struct packed {
        logic [1:0] err_credit_under;
        logic [1:0] err_credit_over;
        logic [1:0] err_vc_onehot;
        logic [1:0] err_smart;
    } link_err_t;

    localparam int LINK_ERRw = $bits(link_err_t);

    function automatic int default_link_stages(input topo_e topo);
        case (topo)
            TOPO_LINE:  return LINK_STAGES_LINE;
            TOPO_RING:  return LINK_STAGES_RING;
            TOPO_MESH:  return LINK_STAGES_MESH;
            default:    return LINK_STAGES_TORUS;
        endcase
    endfunction

    function automatic logic is_onehot(input logic [V_P-1:0] v);
        int ones;
        ones = 0;
        for (int i = 0; i < V_P; i++) ones = ones + int'(v[i]);
        return (ones == 1);
    endfunction

endpackage

// File: rtl/regular_topo_link_pipe_if.sv
// One unidirectional router channel; master drives it, slave observes it.
// Plain wires, no latency; no backpressure (credit flow control lives in the struct).
interface regular_topo_link_pipe_if;
    import regular_topo_link_pipe_pkg::*;

    smartflit_chanel_t chan;

    modport master (output chan);
    modport slave  (input  chan);
endinterface

// File: rtl/regular_topo_link_pipe_dir.sv
// One link direction: STAGES register slices, saturating flit counter, per-VC credit tracker.
// Latency STAGES cycles (0 = wire); no backpressure, every slice loads every cycle.
module regular_topo_link_pipe_dir
    import regular_topo_link_pipe_pkg::*;
#(
    parameter int STAGES   = 1,
    parameter int V        = V_P,
    parameter int B        = 4,
    parameter int CNTw     = 32,
    parameter int CHECK_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  smartflit_chanel_t chan_i,
    input  logic [V-1:0]      credit_i,
    output smartflit_chanel_t chan_o,
    output logic [CNTw-1:0]   flit_cnt_o,
    output logic              err_under_o,
    output logic              err_over_o,
    output logic              err_vc_onehot_o,
    output logic              err_smart_o
);

    localparam int              TRKw    = $clog2(B + 1);
    localparam logic [TRKw-1:0] TRK_MAX = TRKw'(B);
    localparam logic            PIPED   = (STAGES > 0);

    generate
        if (STAGES == 0) begin : g_wire
            assign chan_o = chan_i;
        end else begin : g_pipe
            smartflit_chanel_t stage_q [STAGES];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
                end else begin
                    stage_q[0] <= chan_i;
                    for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign chan_o = stage_q[STAGES-1];
        end
    endgenerate

    logic [CNTw-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (chan_i.flit_wr && (cnt_q != '1)) cnt_d = cnt_q + CNTw'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign flit_cnt_o = cnt_q;

    generate
        if (CHECK_EN != 0) begin : g_chk
            logic [TRKw-1:0] trk_q [V];
            logic [TRKw-1:0] trk_d [V];
            logic under_q, under_d, over_q, over_d;
            logic onehot_q, onehot_d, smart_q, smart_d;

            always_comb begin
                logic dec, inc;
                dec      = 1'b0;
                inc      = 1'b0;
                under_d  = under_q;
                over_d   = over_q;
                for (int v = 0; v < V; v++) begin
                    trk_d[v] = trk_q[v];
                    dec      = chan_i.flit_wr & chan_i.flit.vc[v];
                    inc      = credit_i[v];
                    // Simultaneous flit and credit cancel, even at the bounds.
                    if (dec && !inc) begin
                        if (trk_q[v] == '0) under_d  = 1'b1;
                        else                trk_d[v] = trk_q[v] - TRKw'(1);
                    end else if (inc && !dec) begin
                        if (trk_q[v] == TRK_MAX) over_d   = 1'b1;
                        else                     trk_d[v] = trk_q[v] + TRKw'(1);
                    end
                end
                onehot_d = onehot_q | (chan_i.flit_wr & ~is_onehot(chan_i.flit.vc));
                smart_d  = smart_q | (PIPED & (|chan_i.smart_req));
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int v = 0; v < V; v++) trk_q[v] <= TRK_MAX;
                    under_q  <= 1'b0;
                    over_q   <= 1'b0;
                    onehot_q <= 1'b0;
                    smart_q  <= 1'b0;
                end else begin
                    for (int v = 0; v < V; v++) trk_q[v] <= trk_d[v];
                    under_q  <= under_d;
                    over_q   <= over_d;
                    onehot_q <= onehot_d;
                    smart_q  <= smart_d;
                end
            end

            assign err_under_o     = under_q;
            assign err_over_o      = over_q;
            assign err_vc_onehot_o = onehot_q;
            assign err_smart_o     = smart_q;
        end else begin : g_nochk
            assign err_under_o     = 1'b0;
            assign err_over_o      = 1'b0;
            assign err_vc_onehot_o = 1'b0;
            assign err_smart_o     = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/regular_topo_link_pipe.sv
// Bidirectional pipelined router-to-router link with credit-integrity checking and flit statistics.
// Latency LINK_STAGES cycles each way; no backpressure, relies on the routers' credit flow control.
module regular_topo_link_pipe
    import regular_topo_link_pipe_pkg::*;
#(
    parameter int LINK_STAGES = 1,
    parameter int V           = V_P,
    parameter int B           = 4,
    parameter int CNTw        = 32,
    parameter int CHECK_EN    = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    regular_topo_link_pipe_if.slave  a_chan_out,
    regular_topo_link_pipe_if.master a_chan_in,
    regular_topo_link_pipe_if.slave  b_chan_out,
    regular_topo_link_pipe_if.master b_chan_in,
    output logic [CNTw-1:0]          flit_cnt_ab,
    output logic [CNTw-1:0]          flit_cnt_ba,
    output link_err_t                link_err
);

    smartflit_chanel_t ab_chan, ba_chan;
    logic [1:0] under, over, onehot, smart;

    // Credits for A->B flits are returned by B, hence the cross-wiring.
    regular_topo_link_pipe_dir #(
        .STAGES(LINK_STAGES), .V(V), .B(B), .CNTw(CNTw), .CHECK_EN(CHECK_EN)
    ) u_ab (
        .clk             (clk),
        .reset           (reset),
        .chan_i          (a_chan_out.chan),
        .credit_i        (b_chan_out.chan.credit[V-1:0]),
        .chan_o          (ab_chan),
        .flit_cnt_o      (flit_cnt_ab),
        .err_under_o     (under[0]),
        .err_over_o      (over[0]),
        .err_vc_onehot_o (onehot[0]),
        .err_smart_o     (smart[0])
    );

    regular_topo_link_pipe_dir #(
        .STAGES(LINK_STAGES), .V(V), .B(B), .CNTw(CNTw), .CHECK_EN(CHECK_EN)
    ) u_ba (
        .clk             (clk),
        .reset           (reset),
        .chan_i          (b_chan_out.chan),
        .credit_i        (a_chan_out.chan.credit[V-1:0]),
        .chan_o          (ba_chan),
        .flit_cnt_o      (flit_cnt_ba),
        .err_under_o     (under[1]),
        .err_over_o      (over[1]),
        .err_vc_onehot_o (onehot[1]),
        .err_smart_o     (smart[1])
    );

    assign b_chan_in.chan = ab_chan;
    assign a_chan_in.chan = ba_chan;

    assign link_err.err_credit_under = under;
    assign link_err.err_credit_over  = over;
    assign link_err.err_vc_onehot    = onehot;
    assign link_err.err_smart        = smart;

endmodule

// File: tb/tb_regular_topo_link_pipe.sv
// Directed bench: three link instances (3, 1 and 0 stages) share one stimulus pair.
module tb_regular_topo_link_pipe;
    import regular_topo_link_pipe_pkg::*;

    logic clk;
    logic reset;

    regular_topo_link_pipe_if a_o(), b_o();
    regular_topo_link_pipe_if a_i3(), b_i3(), a_i1(), b_i1(), a_i0(), b_i0();

    logic [31:0] cnt_ab3, cnt_ba3, cnt_ab1, cnt_ba1;
    logic [3:0]  cnt_ab0, cnt_ba0;
    link_err_t   err3, err1, err0;

    int n_vec = 0;
    int n_err = 0;

    regular_topo_link_pipe #(.LINK_STAGES(3), .V(2), .B(4), .CNTw(32), .CHECK_EN(1)) dut3 (
        .clk(clk), .reset(reset),
        .a_chan_out(a_o), .a_chan_in(a_i3), .b_chan_out(b_o), .b_chan_in(b_i3),
        .flit_cnt_ab(cnt_ab3), .flit_cnt_ba(cnt_ba3), .link_err(err3)
    );

    regular_topo_link_pipe #(.LINK_STAGES(1), .V(2), .B(4), .CNTw(32), .CHECK_EN(1)) dut1 (
        .clk(clk), .reset(reset),
        .a_chan_out(a_o), .a_chan_in(a_i1), .b_chan_out(b_o), .b_chan_in(b_i1),
        .flit_cnt_ab(cnt_ab1), .flit_cnt_ba(cnt_ba1), .link_err(err1)
    );

    regular_topo_link_pipe #(.LINK_STAGES(0), .V(2), .B(4), .CNTw(4), .CHECK_EN(1)) dut0 (
        .clk(clk), .reset(reset),
        .a_chan_out(a_o), .a_chan_in(a_i0), .b_chan_out(b_o), .b_chan_in(b_i0),
        .flit_cnt_ab(cnt_ab0), .flit_cnt_ba(cnt_ba0), .link_err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       a_wr;
        logic [1:0] a_vc;
        logic [7:0] a_dat;
        logic [1:0] b_cred;
        logic [1:0] a_smart;
        logic       exp_wr;
        logic [7:0] exp_dat;
        logic [31:0] exp_cnt;
        logic [7:0] exp_err;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl [NV];

    function automatic vec_t mkv(input logic a_wr, input logic [1:0] a_vc, input logic [7:0] a_dat,
                                 input logic [1:0] b_cred, input logic [1:0] a_smart,
                                 input logic exp_wr, input logic [7:0] exp_dat,
                                 input logic [31:0] exp_cnt, input logic [7:0] exp_err);
        vec_t r;
        r.a_wr = a_wr;     r.a_vc = a_vc;       r.a_dat = a_dat;
        r.b_cred = b_cred; r.a_smart = a_smart;
        r.exp_wr = exp_wr; r.exp_dat = exp_dat; r.exp_cnt = exp_cnt; r.exp_err = exp_err;
        return r;
    endfunction

    function automatic smartflit_chanel_t mk(input logic [1:0] vc, input logic [7:0] dat);
        smartflit_chanel_t c;
        c = '0;
        c.flit.hdr     = 1'b1;
        c.flit.vc      = vc;
        c.flit.payload = dat;
        c.flit_wr      = 1'b1;
        c.congestion   = 2'b10;
        c.ctrl         = 2'b01;
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    smartflit_chanel_t fa, fb, fa2, ca, cb;

    initial begin
        //                a_wr  a_vc   a_dat  b_cred a_smart  wr    dat    cnt    err
        tbl[0]  = mkv(1'b0, 2'b00, 8'h00, 2'b00, 2'b00, 1'b0, 8'h00, 32'd0, 8'h00);
        tbl[1]  = mkv(1'b1, 2'b10, 8'hA1, 2'b10, 2'b00, 1'b0, 8'h00, 32'd1, 8'h00);
        tbl[2]  = mkv(1'b0, 2'b00, 8'h00, 2'b10, 2'b00, 1'b0, 8'h00, 32'd1, 8'h10);
        tbl[3]  = mkv(1'b1, 2'b01, 8'h11, 2'b00, 2'b00, 1'b1, 8'hA1, 32'd2, 8'h10);
        tbl[4]  = mkv(1'b1, 2'b01, 8'h22, 2'b00, 2'b00, 1'b0, 8'h00, 32'd3, 8'h10);
        tbl[5]  = mkv(1'b1, 2'b01, 8'h33, 2'b00, 2'b00, 1'b1, 8'h11, 32'd4, 8'h10);
        tbl[6]  = mkv(1'b1, 2'b01, 8'h44, 2'b00, 2'b00, 1'b1, 8'h22, 32'd5, 8'h10);
        tbl[7]  = mkv(1'b1, 2'b01, 8'h55, 2'b00, 2'b00, 1'b1, 8'h33, 32'd6, 8'h50);
        tbl[8]  = mkv(1'b0, 2'b00, 8'h00, 2'b00, 2'b00, 1'b1, 8'h44, 32'd6, 8'h50);
        tbl[9]  = mkv(1'b0, 2'b00, 8'h00, 2'b00, 2'b00, 1'b1, 8'h55, 32'd6, 8'h50);
        tbl[10] = mkv(1'b1, 2'b11, 8'h66, 2'b00, 2'b00, 1'b0, 8'h00, 32'd7, 8'h54);
        tbl[11] = mkv(1'b0, 2'b00, 8'h00, 2'b00, 2'b01, 1'b0, 8'h00, 32'd7, 8'h55);
        tbl[12] = mkv(1'b0, 2'b00, 8'h00, 2'b00, 2'b00, 1'b1, 8'h66, 32'd7, 8'h55);

        reset = 1'b1;
        a_o.chan = '0;
        b_o.chan = '0;
        step();
        step();
        reset = 1'b0;
        step();

        chk("rst_b_chan_in",  64'(b_i3.chan), 64'd0);
        chk("rst_a_chan_in",  64'(a_i3.chan), 64'd0);
        chk("rst_cnt_ab",     64'(cnt_ab3),   64'd0);
        chk("rst_link_err",   64'(err3),      64'd0);

        // Latency: flit presented in cycle 10, expected at the far side in cycle 13.
        repeat (8) step();
        fa = mk(2'b01, 8'h5A);
        fb = mk(2'b10, 8'hB7);
        a_o.chan = fa;
        b_o.chan = fb;
        #1;
        chk("s0_pass_ab", 64'(b_i0.chan), 64'(fa));
        chk("s0_pass_ba", 64'(a_i0.chan), 64'(fb));
        step();
        a_o.chan = '0;
        b_o.chan = '0;
        chk("s3_c11_wr", 64'(b_i3.chan.flit_wr), 64'd0);
        chk("s1_c11_ab", 64'(b_i1.chan), 64'(fa));
        step();
        chk("s3_c12_wr", 64'(b_i3.chan.flit_wr), 64'd0);
        step();
        chk("s3_c13_ab", 64'(b_i3.chan), 64'(fa));
        chk("s3_c13_ba", 64'(a_i3.chan), 64'(fb));
        chk("s3_cnt_ab", 64'(cnt_ab3), 64'd1);
        chk("s3_cnt_ba", 64'(cnt_ba3), 64'd1);
        chk("s3_err",    64'(err3),    64'd0);

        // Reset with two flits still inside the slices.
        fa2 = mk(2'b01, 8'hC3);
        a_o.chan = fa;
        step();
        a_o.chan = fa2;
        step();
        a_o.chan = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_b3",  64'(b_i3.chan), 64'd0);
        chk("midrst_b1",  64'(b_i1.chan), 64'd0);
        chk("midrst_cnt", 64'(cnt_ab3),   64'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("midrst_drain_wr", 64'(b_i3.chan.flit_wr), 64'd0);
        end
        chk("midrst_err", 64'(err3), 64'd0);

        for (int k = 0; k < NV; k++) begin
            ca = '0;
            ca.flit_wr      = tbl[k].a_wr;
            ca.flit.vc      = tbl[k].a_vc;
            ca.flit.payload = tbl[k].a_dat;
            ca.smart_req    = tbl[k].a_smart;
            cb = '0;
            cb.credit       = tbl[k].b_cred;
            a_o.chan = ca;
            b_o.chan = cb;
            step();
            chk($sformatf("tbl%0d_wr", k),  64'(b_i3.chan.flit_wr),      64'(tbl[k].exp_wr));
            chk($sformatf("tbl%0d_dat", k), 64'(b_i3.chan.flit.payload), 64'(tbl[k].exp_dat));
            chk($sformatf("tbl%0d_cnt", k), 64'(cnt_ab3),                64'(tbl[k].exp_cnt));
            chk($sformatf("tbl%0d_err", k), 64'(err3),                   64'(tbl[k].exp_err));
        end
        a_o.chan = '0;
        b_o.chan = '0;
        chk("tbl_err_s1",  64'(err1),    64'h55);
        chk("tbl_err_s0",  64'(err0),    64'h54);
        chk("tbl_cnt_s0",  64'(cnt_ab0), 64'd7);

        // Saturation of the 4-bit counter on the zero-stage instance.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a_o.chan = mk(2'b01, 8'(i));
            if (i < 3) b_o.chan = mk(2'b01, 8'hE0);
            else       b_o.chan = '0;
            step();
            if (i == 14) chk("sat_at_15", 64'(cnt_ab0), 64'd15);
        end
        a_o.chan = '0;
        b_o.chan = '0;
        step();
        chk("sat_cnt_ab0", 64'(cnt_ab0), 64'd15);
        chk("sat_cnt_ba0", 64'(cnt_ba0), 64'd3);
        chk("sat_cnt_ab3", 64'(cnt_ab3), 64'd20);
        chk("sat_cnt_ba3", 64'(cnt_ba3), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
